// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to imem and
// buffers returned {addr, inst} pairs for if_id. Define IF_BYPASS_EN to forward a response straight to the output when the buffer is empty.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hold_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      pc, pc_nxt;
    logic [CNT_W-1:0] outstanding, outstanding_nxt;

    // Addresses of in-flight requests, popped in order as responses return.
    logic [31:0]      aq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] aq_wr, aq_rd;

    logic [31:0]      fq_inst [FIFO_DEPTH];
    logic [31:0]      fq_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] fq_wr, fq_rd;
    logic [CNT_W-1:0] fq_cnt, fq_cnt_nxt;

    logic credit_ok;
    logic issue;
    logic jump_act;
    logic resp_acc;
    logic resp_keep;
    logic fq_empty;
    logic fq_push;
    logic fq_pop;
    logic fq_flush;
    logic byp_take;
    logic byp_consume;

    logic [1:0] unused_jump_lsb;
    assign unused_jump_lsb = jump_addr_i[1:0];

    assign fq_empty = (fq_cnt == '0);

    always_comb begin
        credit_ok = ({1'b0, outstanding} + {1'b0, fq_cnt}) < {1'b0, DEPTH_C};
        jump_act  = jump_en_i && (state != IDLE);
        issue     = (state == FETCH) && credit_ok && !jump_en_i;
        // A response with nothing outstanding is a leftover from before reset.
        resp_acc  = imem_rvalid_i && (outstanding != '0);
        resp_keep = resp_acc && (state == FETCH) && !jump_en_i;
    end

`ifdef IF_BYPASS_EN
    assign byp_take = resp_keep && fq_empty;
`else
    assign byp_take = 1'b0;
`endif

    assign byp_consume = byp_take && !hold_i;
    assign fq_pop      = !fq_empty && !hold_i && !jump_en_i;
    assign fq_push     = resp_keep && !byp_consume;
    assign fq_flush    = jump_act;

    assign imem_req_o  = issue;
    assign imem_addr_o = (state == IDLE) ? 32'h0 : pc;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP;
        instaddr_o   = 32'h0;
        if (!fq_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = fq_inst[fq_rd];
            instaddr_o   = fq_addr[fq_rd];
        end else if (byp_take) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            instaddr_o   = aq_mem[aq_rd];
        end
    end

    always_comb begin
        outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp_acc);

        fq_cnt_nxt = fq_cnt + CNT_W'(fq_push) - CNT_W'(fq_pop);
        if (fq_flush) begin
            fq_cnt_nxt = '0;
        end

        pc_nxt = pc;
        if (jump_act) begin
            pc_nxt = {jump_addr_i[31:2], 2'b00};
        end else if (issue) begin
            pc_nxt = pc + 32'd4;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (jump_act && (outstanding_nxt != '0)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Stale responses drain here; a further jump only retargets pc.
                if (outstanding_nxt == '0) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            fq_wr       <= '0;
            fq_rd       <= '0;
            fq_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= outstanding_nxt;
            fq_cnt      <= fq_cnt_nxt;
            if (issue) begin
                aq_wr <= aq_wr + PTR_W'(1);
            end
            if (resp_acc) begin
                aq_rd <= aq_rd + PTR_W'(1);
            end
            if (fq_flush) begin
                fq_wr <= '0;
                fq_rd <= '0;
            end else begin
                if (fq_push) begin
                    fq_wr <= fq_wr + PTR_W'(1);
                end
                if (fq_pop) begin
                    fq_rd <= fq_rd + PTR_W'(1);
                end
            end
        end
    end

    // Storage is not reset; occupancy is tracked by the pointers and counts above.
    always_ff @(posedge clk) begin
        if (issue) begin
            aq_mem[aq_wr] <= pc;
        end
        if (fq_push) begin
            fq_inst[fq_wr] <= imem_rdata_i;
            fq_addr[fq_wr] <= aq_mem[aq_rd];
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: in-order latency memory model plus a scoreboard of
// expected {addr, inst} pairs pushed at request time and popped when if_id consumes.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IF_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rstn;
    logic        hold_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .hold_i       (hold_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .instaddr_o   (instaddr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_issue  = 0;

    int          mp_due  [$];
    logic [31:0] mp_data [$];
    bit          mp_live [$];
    int          last_due;

    logic [31:0] sb_addr [$];
    logic [31:0] sb_data [$];
    int          sb_arr  [$];
    int          n_arr;
    int          flush_cnt;
    bit          idle_c;
    logic [31:0] model_pc;

    bit          lat_arm;
    int          lat_req_c;
    int          lat_val_c;
    logic [31:0] lat_val_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mp_live[i]) if (mp_live[i]) n++;
        return n;
    endfunction

    task automatic arm_lat();
        lat_arm   = 1'b1;
        lat_req_c = -1;
        lat_val_c = -1;
    endtask

    task automatic tick();
        bit   dv;
        bit   d_live;
        bit   in_flush;
        bit   exp_req;
        bit   exp_valid;
        int   due;
        dv     = 1'b0;
        d_live = 1'b0;
        if (mp_due.size() > 0 && mp_due[0] == cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mp_data[0];
            d_live        = mp_live[0];
            dv            = 1'b1;
            void'(mp_due.pop_front());
            void'(mp_data.pop_front());
            void'(mp_live.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        in_flush = (flush_cnt > 0);
        if (dv) begin
            if (d_live) begin
                if (n_arr < sb_arr.size()) begin
                    sb_arr[n_arr] = cyc;
                    n_arr++;
                end
            end else if (flush_cnt > 0) begin
                flush_cnt--;
            end
        end
        exp_req   = !idle_c && !in_flush && (sb_addr.size() < DEPTH) && !jump_en_i;
        exp_valid = (n_arr > 0) && ((sb_arr[0] < cyc) || (BYP == 1 && !jump_en_i));

        check_eq("req", 32'(imem_req_o), 32'(exp_req));
        if (imem_req_o) begin
            check_eq("addr", imem_addr_o, model_pc);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mp_due.push_back(due);
            mp_data.push_back(memf(imem_addr_o));
            mp_live.push_back(1'b1);
            sb_addr.push_back(model_pc);
            sb_data.push_back(memf(model_pc));
            sb_arr.push_back(-1);
            model_pc = model_pc + 32'd4;
            n_issue++;
            if (lat_arm && lat_req_c < 0) lat_req_c = cyc;
        end

        check_eq("valid", 32'(inst_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("instaddr", instaddr_o, sb_addr[0]);
            check_eq("inst", inst_o, sb_data[0]);
        end else begin
            check_eq("instaddr_empty", instaddr_o, 32'h0);
            check_eq("inst_nop", inst_o, NOP);
        end
        if (lat_arm && lat_req_c >= 0 && lat_val_c < 0 && inst_valid_o) begin
            lat_val_c    = cyc;
            lat_val_addr = instaddr_o;
        end

        if (jump_en_i && !idle_c) begin
            sb_addr.delete();
            sb_data.delete();
            sb_arr.delete();
            n_arr = 0;
            foreach (mp_live[i]) mp_live[i] = 1'b0;
            flush_cnt = mp_due.size();
            model_pc  = {jump_addr_i[31:2], 2'b00};
        end else if (exp_valid && !hold_i) begin
            void'(sb_addr.pop_front());
            void'(sb_data.pop_front());
            void'(sb_arr.pop_front());
            n_arr--;
        end
        idle_c = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit strays);
        rstn          = 1'b1;
        hold_i        = 1'b0;
        jump_en_i     = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        check_eq("rst_req", 32'(imem_req_o), 32'h0);
        check_eq("rst_addr", imem_addr_o, 32'h0);
        check_eq("rst_valid", 32'(inst_valid_o), 32'h0);
        check_eq("rst_inst", inst_o, NOP);
        check_eq("rst_instaddr", instaddr_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mp_due.delete();
        mp_data.delete();
        mp_live.delete();
        sb_addr.delete();
        sb_data.delete();
        sb_arr.delete();
        n_arr     = 0;
        flush_cnt = 0;
        model_pc  = RESET_PC;
        idle_c    = 1'b1;
        last_due  = cyc;
        if (strays) begin
            mp_due.push_back(cyc);
            mp_data.push_back(32'hDEAD_BEEF);
            mp_live.push_back(1'b0);
            mp_due.push_back(cyc + 1);
            mp_data.push_back(32'hCAFE_F00D);
            mp_live.push_back(1'b0);
            last_due = cyc + 1;
        end
        rstn = 1'b0;
    endtask

    task automatic wait_live(input int n);
        for (int i = 0; i < 20 && live_cnt() < n; i++) tick();
        check_eq("wait_live", 32'(live_cnt() >= n), 32'h1);
    endtask

    task automatic jump_to(input logic [31:0] a);
        jump_addr_i = a;
        jump_en_i   = 1'b1;
        tick();
        jump_en_i   = 1'b0;
    endtask

    initial begin
        int iss0;
        rstn          = 1'b1;
        hold_i        = 1'b0;
        jump_en_i     = 1'b0;
        jump_addr_i   = 32'h0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        lat_arm       = 1'b0;

        // Start-up at latency 1: address sequence and first-output latency.
        lat = 1;
        arm_lat();
        do_reset(1'b0);
        repeat (10) tick();
        check_eq("lat_first", 32'(lat_val_c - lat_req_c), 32'(2 - BYP));
        check_eq("first_addr", lat_val_addr, RESET_PC);

        // Downstream hold: credit limits issues, output stable, drain in order afterwards.
        hold_i = 1'b1;
        iss0   = n_issue;
        repeat (5) tick();
        check_eq("hold_issues", 32'((n_issue - iss0) <= DEPTH), 32'h1);
        check_eq("hold_req_low", 32'(imem_req_o), 32'h0);
        hold_i = 1'b0;
        repeat (10) tick();

        // Random hold with a full buffer: simultaneous push and pop.
        for (int i = 0; i < 40; i++) begin
            hold_i = ($urandom_range(0, 2) == 0);
            tick();
        end
        lat = 2;
        for (int i = 0; i < 30; i++) begin
            hold_i = ($urandom_range(0, 2) == 0);
            tick();
        end
        hold_i = 1'b0;

        // Redirect with two requests in flight at latency 3.
        lat = 3;
        repeat (4) tick();
        wait_live(2);
        jump_to(32'h0000_2003);
        arm_lat();
        repeat (15) tick();
        check_eq("jump_lat", 32'(lat_val_c - lat_req_c), 32'(4 - BYP));
        check_eq("jump_tgt", lat_val_addr, 32'h0000_2000);

        // Second redirect while still flushing.
        wait_live(2);
        jump_to(32'h0000_3000);
        jump_to(32'h0000_4009);
        arm_lat();
        repeat (15) tick();
        check_eq("jump_flush_tgt", lat_val_addr, 32'h0000_4008);

        // Reset in the middle of a flush; stray responses afterwards are ignored.
        wait_live(1);
        jump_to(32'h0000_5000);
        arm_lat();
        do_reset(1'b1);
        repeat (15) tick();
        check_eq("rst_restart_addr", lat_val_addr, RESET_PC);
        check_eq("rst_restart_lat", 32'(lat_val_c - lat_req_c), 32'(4 - BYP));

        // Mixed traffic: varying latency, holds and redirects.
        for (int i = 0; i < 300; i++) begin
            if ((i % 16) == 0) lat = $urandom_range(1, 4);
            hold_i = ($urandom_range(0, 3) == 0);
            if (!idle_c && $urandom_range(0, 15) == 0) begin
                jump_addr_i = $urandom;
                jump_en_i   = 1'b1;
            end
            tick();
            jump_en_i = 1'b0;
        end
        hold_i = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction fetch stage directly upstream of if_id/id. Owns the PC, issues word requests to instruction memory over a request/response interface, and buffers returned words with their addresses in a small FIFO. Presents one {instaddr, inst} pair per cycle to if_id; honours a downstream hold and a redirect from ex.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, entries in the instruction buffer; power of two, 2..8; also the credit limit on in-flight requests.

Ports:
clk  input  1  core clock, rising edge.
rstn  input  1  reset.
hold_i  input  1  downstream stall; output pair not consumed this cycle.
jump_en_i  input  1  redirect request from ex.
jump_addr_i  input  32  redirect target.
imem_req_o  output  1  fetch request valid, one word per cycle.
imem_addr_o  output  32  fetch address, word aligned.
imem_rvalid_i  input  1  response valid; responses return in request order, latency >= 1 cycle.
imem_rdata_i  input  32  response instruction word.
inst_valid_o  output  1  inst_o/instaddr_o hold a real instruction.
inst_o  output  32  instruction to if_id.
instaddr_o  output  32  address of inst_o.

Behaviour:
- One clock; reset is asynchronous and active-high. rstn is the reset port; rstn=1 resets.
- Reset values: pc=RESET_PC, FIFO empty, outstanding=0, state=IDLE, imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), instaddr_o=0. Reset mid-operation discards all in-flight and buffered state; any response after reset is ignored.
- Credit: issue allowed when outstanding + fifo_count < FIFO_DEPTH. Guarantees every accepted response fits; FIFO never overflows.
- imem_req_o is combinational = (state==FETCH) && credit available && !jump_en_i; imem_addr_o = pc. On issue: pc <= pc+4 (wraps at 2^32), outstanding +1, pc pushed into address queue.
- Response (imem_rvalid_i) in FETCH: pops address queue, pushes {addr, rdata} into FIFO, outstanding -1. Response with outstanding==0 is ignored.
- Output: FIFO head drives inst_o/instaddr_o/inst_valid_o. Empty: inst_valid_o=0, inst_o=NOP, instaddr_o=0. Pop when inst_valid_o && !hold_i. Push and pop in same cycle legal, count unchanged.
- Latency: request in cycle N, response N+L, inst_valid_o at N+L+1 (without optional feature).
- FSM:
  IDLE: entered from reset; one cycle, then FETCH.
  FETCH: normal operation. jump_en_i -> pc <= {jump_addr_i[31:2],2'b00}, FIFO flushed, then FLUSH if outstanding after this cycle's response > 0, else stay FETCH.
  FLUSH: no requests; every response dropped, outstanding -1; outstanding reaching 0 -> FETCH next cycle. jump_en_i in FLUSH updates pc, stays FLUSH.
- Priority: jump_en_i > hold_i > normal pop. Response arriving in the jump cycle is dropped. Output in the jump cycle is not consumed by if_id (ex flushes it).
- outstanding counter width clog2(FIFO_DEPTH)+1; never exceeds FIFO_DEPTH.

Optional Feature:
IF_BYPASS_EN. Defined: when FIFO empty, state==FETCH, imem_rvalid_i=1 and !jump_en_i, the response drives inst_o/instaddr_o/inst_valid_o combinationally in the same cycle; if !hold_i it is consumed and not pushed, otherwise it is pushed. Latency becomes N+L. Undefined: all responses go through the FIFO; latency N+L+1.

Test Plan:
- Reset with RESET_PC=32'h0000_0100, memory latency 1, hold_i=0 -> imem_addr_o 0x100,0x104,0x108 on consecutive cycles; inst_valid_o first high 2 cycles after first request with instaddr_o=0x100.
- hold_i=1 for 5 cycles, FIFO_DEPTH=2 -> at most 2 issues, imem_req_o low, inst_o/instaddr_o stable; release -> drain in order, no loss or duplication.
- Latency 3 memory, jump_en_i=1, jump_addr_i=32'h0000_2003 with 2 outstanding -> FLUSH, both responses dropped, next request address 0x2000, first valid instaddr_o=0x2000.
- Push and pop same cycle with FIFO full under latency 1 -> count stays 2, order preserved.
- Assert rstn mid-flush with 1 outstanding, deassert, late response arrives -> ignored, fetch restarts at RESET_PC.
- With IF_BYPASS_EN, empty FIFO, latency 1 -> inst_valid_o high in response cycle; without -> one cycle later.
